// File: rtl/mesa_pkg.sv
// mesa_pkg: definitions shared by the mesa serial output path.
//   tx_state_t   shifter FSM encoding (IDLE/START/DATA/STOP, 2-bit)
//   ASCII_*      character constants used by the converter and benches
//   frame_cycles clock cycles occupied by one frame on the line
package mesa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // start bit + 8 data bits + stop bits, each baud_div cycles long
  function automatic int unsigned frame_cycles(int unsigned baud_div,
                                               int unsigned stop_bits);
    return (9 + stop_bits) * baud_div;
  endfunction

endpackage

// File: rtl/mesa_baud_tick.sv
// mesa_baud_tick: 16-bit loadable down-counter that times one serial bit.
//   clk    system clock
//   reset  synchronous active-high reset, clears the counter
//   load   reload with BAUD_DIV-1 (state entry / bit boundary)
//   tick   high while the counter is 0, i.e. the last cycle of a bit
module mesa_baud_tick
  import mesa_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV = 16'd104
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  logic [15:0] cnt_reg;

  // The counter only restarts on an explicit load, so every frame is
  // phase-aligned to its own start bit rather than to a free-running divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= 16'd0;
    end else if (load) begin
      cnt_reg <= BAUD_DIV - 16'd1;
    end else if (cnt_reg != 16'd0) begin
      cnt_reg <= cnt_reg - 16'd1;
    end
  end

  assign tick = (cnt_reg == 16'd0);

endmodule

// File: rtl/mesa_uart_tx.sv
// mesa_uart_tx: one-entry holding register plus 8N1/8N2 serial shifter.
//   clk           system clock
//   reset         synchronous active-high reset (aborts any frame)
//   tx_char_d     character to send, sampled when tx_char_en=1
//   tx_char_en    single-cycle load strobe
//   tx_char_busy  holding register full (registered)
//   tx_char_idle  holding register empty and shifter idle (registered)
//   tx_overrun    one-cycle pulse when a strobe hits a full holding register
//   txd           serial line, LSB first, idles at 1 (mark)
module mesa_uart_tx
  import mesa_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV  = 16'd104,
  parameter int          STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_char_d,
  input  logic       tx_char_en,
  output logic       tx_char_busy,
  output logic       tx_char_idle,
  output logic       tx_overrun,
  output logic       txd
);

  // index of the final stop bit: 0 for one stop bit, 1 for two
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_t   state_reg;
  logic [7:0]  sr_reg;
  logic [2:0]  bit_cnt_reg;
  logic        stop_cnt_reg;
  logic [7:0]  hold_d_reg;
  logic        hold_v_reg;
  logic        txd_reg;
  logic        busy_reg;
  logic        idle_reg;
  logic        overrun_reg;

  logic        tick;
  logic        baud_load;
  logic        stop_done;
  logic        xfer;
  logic        hold_v_next;
  logic        hold_load;
  logic        overrun_next;

  mesa_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .load  (baud_load),
    .tick  (tick)
  );

  always_comb begin
    stop_done = (state_reg == ST_STOP) && tick && (stop_cnt_reg == STOP_LAST);
    // hold register moves into the shifter from IDLE, or straight from the
    // end of the last stop bit so back-to-back frames have no mark gap
    xfer      = hold_v_reg && ((state_reg == ST_IDLE) || stop_done);
    baud_load = (state_reg == ST_IDLE) ? hold_v_reg : tick;
    // a strobe in the same cycle as a transfer refills the freed slot
    hold_load    = tx_char_en && (xfer || !hold_v_reg);
    hold_v_next  = xfer ? tx_char_en : (hold_v_reg || tx_char_en);
    overrun_next = tx_char_en && hold_v_reg && !xfer;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      sr_reg       <= 8'd0;
      bit_cnt_reg  <= 3'd0;
      stop_cnt_reg <= 1'b0;
      hold_d_reg   <= 8'd0;
      hold_v_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      idle_reg     <= 1'b1;
      overrun_reg  <= 1'b0;
    end else begin
      hold_v_reg  <= hold_v_next;
      busy_reg    <= hold_v_next;
      overrun_reg <= overrun_next;
      if (hold_load) begin
        hold_d_reg <= tx_char_d;
      end
      idle_reg <= 1'b0;

      // txd_reg is loaded with the level of the state being entered, so the
      // line changes in the same cycle the new state becomes visible
      case (state_reg)
        ST_IDLE: begin
          if (hold_v_reg) begin
            sr_reg    <= hold_d_reg;
            state_reg <= ST_START;
            txd_reg   <= 1'b0;
          end else begin
            txd_reg  <= 1'b1;
            idle_reg <= !hold_v_next;
          end
        end
        ST_START: begin
          if (tick) begin
            state_reg   <= ST_DATA;
            bit_cnt_reg <= 3'd0;
            txd_reg     <= sr_reg[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_reg == 3'd7) begin
              state_reg    <= ST_STOP;
              stop_cnt_reg <= 1'b0;
              txd_reg      <= 1'b1;
            end else begin
              sr_reg      <= {1'b0, sr_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              txd_reg     <= sr_reg[1];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop_cnt_reg == STOP_LAST) begin
              if (hold_v_reg) begin
                sr_reg    <= hold_d_reg;
                state_reg <= ST_START;
                txd_reg   <= 1'b0;
              end else begin
                state_reg <= ST_IDLE;
                txd_reg   <= 1'b1;
                idle_reg  <= !hold_v_next;
              end
            end else begin
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          txd_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign tx_char_busy = busy_reg;
  assign tx_char_idle = idle_reg;
  assign tx_overrun   = overrun_reg;
  assign txd          = txd_reg;

endmodule

// File: tb/tb_mesa_uart_tx.sv
// tb_mesa_uart_tx: drives two transmitters (BAUD_DIV=4/1 stop bit and
// BAUD_DIV=2/2 stop bits) and compares every cycle against a frame-level
// model: a transmitter is either idle or at position pos inside a frame of
// (9+stop)*baud cycles, and the line level follows from pos alone.
module tb_mesa_uart_tx;
  import mesa_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0, d1;
  logic       en0, en1;
  logic       busy0, idle0, ovr0, txd0;
  logic       busy1, idle1, ovr1, txd1;

  always #5 clk = ~clk;

  mesa_uart_tx #(.BAUD_DIV(16'd4), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_char_d(d0), .tx_char_en(en0),
    .tx_char_busy(busy0), .tx_char_idle(idle0), .tx_overrun(ovr0), .txd(txd0)
  );

  mesa_uart_tx #(.BAUD_DIV(16'd2), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .tx_char_d(d1), .tx_char_en(en1),
    .tx_char_busy(busy1), .tx_char_idle(idle1), .tx_overrun(ovr1), .txd(txd1)
  );

  // ---------------- behavioural model (index 0 -> dut0, 1 -> dut1)
  int         m_bd [2];
  int         m_sb [2];
  bit         m_act[2];
  int         m_pos[2];
  logic [7:0] m_fd [2];
  logic [7:0] m_hd [2];
  bit         m_hv [2];
  bit         m_ovr[2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ovr_seen0 = 0;

  function automatic logic line_bit(int m);
    int idx;
    if (!m_act[m]) return 1'b1;
    idx = m_pos[m] / m_bd[m];
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_fd[m][idx-1];
    return 1'b1;
  endfunction

  task automatic model_step(input int m, input logic rst, input logic en,
                            input logic [7:0] d);
    if (rst) begin
      m_act[m] = 0; m_pos[m] = 0; m_hv[m] = 0; m_ovr[m] = 0; m_hd[m] = 8'd0;
      return;
    end
    if (m_act[m]) begin
      m_pos[m]++;
      if (m_pos[m] == (9 + m_sb[m]) * m_bd[m]) m_act[m] = 0;
    end
    if (!m_act[m] && m_hv[m]) begin
      m_act[m] = 1; m_pos[m] = 0; m_fd[m] = m_hd[m]; m_hv[m] = 0;
    end
    m_ovr[m] = 0;
    if (en) begin
      if (m_hv[m]) begin
        m_ovr[m] = 1;
        $display("cycle %0d dut%0d strobe 0x%02h dropped (overrun)", cyc, m, d);
      end else begin
        m_hv[m] = 1; m_hd[m] = d;
        $display("cycle %0d dut%0d strobe 0x%02h accepted", cyc, m, d);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    chk("txd0",  int'(txd0),  int'(line_bit(0)));
    chk("busy0", int'(busy0), int'(m_hv[0]));
    chk("idle0", int'(idle0), int'(!m_act[0] && !m_hv[0]));
    chk("ovr0",  int'(ovr0),  int'(m_ovr[0]));
    chk("txd1",  int'(txd1),  int'(line_bit(1)));
    chk("busy1", int'(busy1), int'(m_hv[1]));
    chk("idle1", int'(idle1), int'(!m_act[1] && !m_hv[1]));
    chk("ovr1",  int'(ovr1),  int'(m_ovr[1]));
    if (ovr0 === 1'b1) ovr_seen0++;
  endtask

  // one clock: apply inputs, model the edge, then compare on the falling edge
  task automatic cycle(input logic rst, input logic e0, input logic [7:0] x0,
                       input logic e1, input logic [7:0] x1);
    reset = rst; en0 = e0; d0 = x0; en1 = e1; d1 = x1;
    @(posedge clk);
    cyc++;
    model_step(0, rst, e0, x0);
    model_step(1, rst, e1, x1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cyc();
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic wait_idle(input int sel, inout int off);
    while (!(sel != 0 ? idle1 : idle0) && off < 400) begin
      idle_cyc();
      off++;
    end
  endtask

  logic pat [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int off;
    int w;
    m_bd[0] = 4; m_sb[0] = 1;
    m_bd[1] = 2; m_sb[1] = 2;
    for (int m = 0; m < 2; m++) begin
      m_act[m] = 0; m_pos[m] = 0; m_hv[m] = 0; m_ovr[m] = 0;
      m_fd[m] = 8'd0; m_hd[m] = 8'd0;
    end
    reset = 1'b1; en0 = 1'b0; en1 = 1'b0; d0 = 8'd0; d1 = 8'd0;
    @(negedge clk);

    // reset state
    repeat (3) cycle(1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
    chk("rst_txd", int'(txd0), 1);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_idle", int'(idle0), 1);
    repeat (3) idle_cyc();

    // 8'h41 frame, BAUD_DIV=4
    cycle(1'b0, 1'b1, 8'h41, 1'b0, 8'd0);
    chk("a_busy1", int'(busy0), 1);
    chk("a_idle1", int'(idle0), 0);
    for (int o = 2; o <= 44; o++) begin
      idle_cyc();
      if (o == 2) chk("a_busy2", int'(busy0), 0);
      if (o < 42 && ((o - 2) % 4) == 0) chk("a_bit", int'(txd0), int'(pat[(o - 2) / 4]));
      if (o == 41) chk("a_idle41", int'(idle0), 0);
      if (o == 42) chk("a_idle42", int'(idle0), 1);
    end

    // back-to-back 8'h30 then line feed: 80 cycles of line activity, no gap
    ovr_seen0 = 0;
    cycle(1'b0, 1'b1, 8'h30, 1'b0, 8'd0);
    off = 1; w = 0;
    while (busy0 && w < 10) begin idle_cyc(); off++; w++; end
    chk("b_busy_clear", int'(busy0), 0);
    cycle(1'b0, 1'b1, ASCII_LF, 1'b0, 8'd0);
    off++;
    wait_idle(0, off);
    chk("b_idle_at", off, 82);
    chk("b_ovr_count", ovr_seen0, 0);

    // overrun: second strobe while hold register is full
    repeat (2) idle_cyc();
    ovr_seen0 = 0;
    cycle(1'b0, 1'b1, 8'h55, 1'b0, 8'd0);
    idle_cyc();
    cycle(1'b0, 1'b1, 8'h11, 1'b0, 8'd0);
    idle_cyc();
    cycle(1'b0, 1'b1, 8'h22, 1'b0, 8'd0);
    off = 5;
    wait_idle(0, off);
    chk("c_ovr_count", ovr_seen0, 1);
    chk("c_idle_at", off, 82);

    // reset during data bit 3, with a strobe that must be discarded
    repeat (2) idle_cyc();
    cycle(1'b0, 1'b1, 8'hA5, 1'b0, 8'd0);
    for (int o = 2; o <= 19; o++) idle_cyc();
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 8'd0);
    chk("d_txd", int'(txd0), 1);
    chk("d_busy", int'(busy0), 0);
    chk("d_idle", int'(idle0), 1);
    repeat (3) idle_cyc();
    cycle(1'b0, 1'b1, 8'hFF, 1'b0, 8'd0);
    off = 1;
    wait_idle(0, off);
    chk("d_ff_idle_at", off, 42);

    // two stop bits, BAUD_DIV=2, 8'h00
    repeat (2) idle_cyc();
    cycle(1'b0, 1'b0, 8'd0, 1'b1, 8'h00);
    for (int o = 2; o <= 24; o++) begin
      idle_cyc();
      if (o <= 19) chk("e_low", int'(txd1), 0);
      else if (o <= 23) chk("e_high", int'(txd1), 1);
      if (o == 23) chk("e_idle23", int'(idle1), 0);
      if (o == 24) chk("e_idle24", int'(idle1), 1);
    end

    // randomized traffic on both transmitters, with rare resets
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 399) == 0),
            ($urandom_range(0, 11) == 0), 8'($urandom),
            ($urandom_range(0, 7) == 0), 8'($urandom));
    end
    repeat (60) idle_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
